pipeline_hazard_ctrl: RTL

//  Sequences the IF/ID/EXE/MEM pipeline registers of the ARM core. Generates freeze/flush for the
//  IF and ID_Stage_Reg-style stage registers from RAW hazards, taken branches and SRAM wait states.

---
 rtl/arm_pkg.sv | 12 +
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 37 +++
 rtl/pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared types for the ARM core pipeline control: sequencer states and architectural register ids.
package arm_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Read-after-write hazard check between the ID operands and the EXE/MEM destinations.
module hazard_detect (
    input  logic [3:0] src1,
    input  logic [3:0] src2,
    input  logic       id_uses_src1,
    input  logic       two_src,
    input  logic       fwd_en,
    input  logic       exe_wb_en,
    input  logic [3:0] exe_dest,
    input  logic       exe_mem_r_en,
    input  logic       mem_wb_en,
    input  logic [3:0] mem_dest,
    output logic       hz
);

    logic [3:0] src [2];
    logic [1:0] src_used;
    logic [1:0] src_match;

    assign src[0]   = src1;
    assign src[1]   = src2;
    assign src_used = {two_src, id_uses_src1};

    // With forwarding only a load in EXE cannot be bypassed; without it any pending write stalls.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic exe_hit;
            logic mem_hit;
            assign exe_hit = exe_wb_en & (exe_dest == src[gi]) & (~fwd_en | exe_mem_r_en);
            assign mem_hit = mem_wb_en & (mem_dest == src[gi]) & ~fwd_en;
            assign src_match[gi] = src_used[gi] & (exe_hit | mem_hit);
        end
    endgenerate

    assign hz = |src_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline freeze/flush sequencer: RAW stalls, taken-branch flushes, SRAM wait states,
// plus saturating stall/flush counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl
    import arm_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             two_src,
    input  logic             id_uses_src1,
    input  logic             exe_wb_en,
    input  logic [3:0]       exe_dest,
    input  logic             exe_mem_r_en,
    input  logic             mem_wb_en,
    input  logic [3:0]       mem_dest,
    input  logic             fwd_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             if_freeze,
    output logic             id_freeze,
    output logic             id_flush,
    output logic             if_flush,
    output logic             exe_freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [2:0]       flush_ctr_q, flush_ctr_d;
    logic [7:0]       wait_ctr_q, wait_ctr_d;
    logic             branch_pend_q, branch_pend_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hz;
    logic             mem_stall;

    assign mem_stall = mem_req & ~mem_ready;

    hazard_detect u_hazard_detect (
        .src1         (src1),
        .src2         (src2),
        .id_uses_src1 (id_uses_src1),
        .two_src      (two_src),
        .fwd_en       (fwd_en),
        .exe_wb_en    (exe_wb_en),
        .exe_dest     (exe_dest),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_wb_en    (mem_wb_en),
        .mem_dest     (mem_dest),
        .hz           (hz)
    );

    always_comb begin
        if_freeze     = 1'b0;
        id_freeze     = 1'b0;
        id_flush      = 1'b0;
        if_flush      = 1'b0;
        exe_freeze    = 1'b0;
        state_d       = state_q;
        flush_ctr_d   = flush_ctr_q;
        wait_ctr_d    = wait_ctr_q;
        branch_pend_d = branch_pend_q;
        mem_timeout_d = mem_timeout_q;

        case (state_q)
            RUN: begin
                // A stalled SRAM access outranks a branch; the branch is remembered for later.
                if (mem_stall) begin
                    {if_freeze, id_freeze, exe_freeze} = 3'b111;
                    state_d       = MEM_WAIT;
                    branch_pend_d = branch_taken;
                end else if (branch_taken) begin
                    {if_flush, id_flush} = 2'b11;
                    state_d     = FLUSH;
                    flush_ctr_d = FLUSH_INIT;
                end else if (hz) begin
                    if_freeze = 1'b1;
                    id_flush  = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (branch_taken)
                    branch_pend_d = 1'b1;
                if (mem_ready) begin
                    wait_ctr_d = 8'd0;
                    if (branch_pend_q | branch_taken) begin
                        state_d       = FLUSH;
                        flush_ctr_d   = FLUSH_INIT;
                        branch_pend_d = 1'b0;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    {if_freeze, id_freeze, exe_freeze} = 3'b111;
                    wait_ctr_d = (wait_ctr_q == TIMEOUT_LIM) ? TIMEOUT_LIM : wait_ctr_q + 8'd1;
                    if (wait_ctr_d == TIMEOUT_LIM)
                        mem_timeout_d = 1'b1;
                end
            end
            FLUSH: begin
                // A branch cannot resolve here: the instruction in EXE is itself a flushed bubble.
                if (mem_stall) begin
                    {if_freeze, id_freeze, exe_freeze} = 3'b111;
                    state_d       = MEM_WAIT;
                    branch_pend_d = 1'b1;
                end else begin
                    {if_flush, id_flush} = 2'b11;
                    if (flush_ctr_q == 3'd0)
                        state_d = RUN;
                    else
                        flush_ctr_d = flush_ctr_q - 3'd1;
                end
            end
            default: state_d = RUN;
        endcase

        if (!rst) begin
            if_freeze  = 1'b0;
            id_freeze  = 1'b0;
            id_flush   = 1'b0;
            if_flush   = 1'b0;
            exe_freeze = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (if_freeze && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;

        flush_cnt_d = flush_cnt_q;
        if ((state_d == FLUSH) && (state_q != FLUSH) && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RUN;
            flush_ctr_q   <= 3'd0;
            wait_ctr_q    <= 8'd0;
            branch_pend_q <= 1'b0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            flush_ctr_q   <= flush_ctr_d;
            wait_ctr_q    <= wait_ctr_d;
            branch_pend_q <= branch_pend_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign mem_timeout = mem_timeout_q;

endmodule
